// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain stage: default sizes, the data word type
// and the pointer/occupancy width helper.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int SKID_DEPTH_DEF = 2;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

    // Bits needed to index 'depth' entries; never less than one bit.
    function automatic int ptr_width(input int depth);
        if (depth > 2) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/fifo_drain_skid_buf.sv
// Circular skid buffer that catches FIFO read data one cycle after the strobe and
// presents the head entry with zero latency.
module fifo_drain_skid_buf
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int SKID_DEPTH = SKID_DEPTH_DEF,
    localparam int PTR_W      = ptr_width(SKID_DEPTH),
    localparam int OCC_W      = ptr_width(SKID_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    input  logic                  i_clr,
    output logic [OCC_W-1:0]      o_occ,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_buf [SKID_DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [OCC_W-1:0]      r_occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(SKID_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Storage, pointers and occupancy; clear drops contents but keeps the array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head <= {PTR_W{1'b0}};
            r_tail <= {PTR_W{1'b0}};
            r_occ  <= {OCC_W{1'b0}};
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_buf[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (i_clr) begin
            r_head <= {PTR_W{1'b0}};
            r_tail <= {PTR_W{1'b0}};
            r_occ  <= {OCC_W{1'b0}};
        end else begin
            if (i_wr) begin
                r_buf[r_tail] <= i_wdata;
                r_tail        <= ptr_inc(r_tail);
            end
            if (i_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({i_wr, i_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_data = r_buf[r_head];

endmodule

// File: rtl/fifo_drain_ctrl.sv
// FIFO consumer: issues read strobes with credit for buffered plus in-flight words,
// drives the skid buffer, and counts beats accepted by the downstream sink.
module fifo_drain_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SKID_DEPTH = SKID_DEPTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  rd_en,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  words_out
);

    localparam int OCC_W = ptr_width(SKID_DEPTH + 1);
    localparam int LVL_W = OCC_W + 1;

    logic                 r_inflight;
    logic [CNT_WIDTH-1:0] r_words_out;
    logic [OCC_W-1:0]     w_occ;
    logic [LVL_W-1:0]     w_level;
    logic                 w_pop;
    logic                 w_wr;

    assign out_valid = (w_occ != {OCC_W{1'b0}});
    assign w_pop     = out_valid & out_ready;
    assign w_wr      = r_inflight & ~flush;
    assign words_out = r_words_out;

    // Read strobe: the pop this cycle frees a slot in time for a word read now.
    always_comb begin
        rd_en   = 1'b0;
        w_level = {1'b0, w_occ} + LVL_W'(r_inflight) - LVL_W'(w_pop);
        if (reset && !fifo_empty && !flush && (w_level < LVL_W'(SKID_DEPTH))) begin
            rd_en = 1'b1;
        end else begin
            rd_en = 1'b0;
        end
    end

    // In-flight flag and accepted-beat counter; flush leaves the counter alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight  <= 1'b0;
            r_words_out <= {CNT_WIDTH{1'b0}};
        end else begin
            r_inflight <= rd_en;
            if (w_pop) begin
                r_words_out <= r_words_out + CNT_WIDTH'(1);
            end else begin
                r_words_out <= r_words_out;
            end
        end
    end

    fifo_drain_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid_buf (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (w_wr),
        .i_wdata (fifo_data),
        .i_pop   (w_pop),
        .i_clr   (flush),
        .o_occ   (w_occ),
        .o_data  (out_data)
    );

endmodule
